// File: rtl/byte_lane_reader.sv
// Splits a 16-bit word into its enabled byte lanes, emitting lane 0 before lane 1.
// Words with no enabled lanes are counted as dropped and produce no output.
module byte_lane_reader #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [1:0]       in_byteena,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_lane,
    output logic             out_last,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [15:0]      word_r;
    logic [1:0]       be_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [CNT_W-1:0] byte_cnt_r;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             out_valid_s;
    logic [7:0]       out_data_s;
    logic             out_lane_s;
    logic             out_last_s;

    // Next-state selection; a stalled byte keeps the current state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    case (in_byteena)
                        2'b11:   state_nxt_s = LO;
                        2'b01:   state_nxt_s = LO;
                        2'b10:   state_nxt_s = HI;
                        default: state_nxt_s = IDLE;
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LO: begin
                if (out_ready) begin
                    state_nxt_s = be_r[1] ? HI : IDLE;
                end else begin
                    state_nxt_s = LO;
                end
            end
            HI: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HI;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode straight from state so an asynchronous reset clears it at once.
    always_comb begin
        out_valid_s = 1'b0;
        out_data_s  = 8'h00;
        out_lane_s  = 1'b0;
        out_last_s  = 1'b0;
        case (state_r)
            LO: begin
                out_valid_s = 1'b1;
                out_data_s  = word_r[7:0];
                out_lane_s  = 1'b0;
                out_last_s  = ~be_r[1];
            end
            HI: begin
                out_valid_s = 1'b1;
                out_data_s  = word_r[15:8];
                out_lane_s  = 1'b1;
                out_last_s  = 1'b1;
            end
            default: begin
                out_valid_s = 1'b0;
                out_data_s  = 8'h00;
                out_lane_s  = 1'b0;
                out_last_s  = 1'b0;
            end
        endcase
    end

    // Handshake qualifiers.
    always_comb begin
        in_xfer_s  = in_valid && (state_r == IDLE);
        out_xfer_s = out_valid_s && out_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Word and lane-enable capture, only while accepting.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            word_r <= 16'h0000;
            be_r   <= 2'b00;
        end else if (in_xfer_s) begin
            word_r <= in_data;
            be_r   <= in_byteena;
        end else begin
            word_r <= word_r;
            be_r   <= be_r;
        end
    end

    // Dropped-word and emitted-byte counters, wrapping naturally.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            drop_cnt_r <= {CNT_W{1'b0}};
            byte_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (in_xfer_s && (in_byteena == 2'b00)) begin
                drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end
            if (out_xfer_s) begin
                byte_cnt_r <= byte_cnt_r + CNT_ONE;
            end
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign out_lane  = out_lane_s;
    assign out_last  = out_last_s;
    assign drop_cnt  = drop_cnt_r;
    assign byte_cnt  = byte_cnt_r;

endmodule

// File: tb/tb_byte_lane_reader.sv
// Directed testbench for byte_lane_reader: inputs change on the falling edge,
// outputs are checked on the falling edge, one task per scenario.
module tb_byte_lane_reader;

    logic        clk;
    logic        areset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_byteena;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_lane;
    logic        out_last;
    logic [7:0]  drop_cnt;
    logic [7:0]  byte_cnt;

    int pass_cnt;
    int total_cnt;
    logic [7:0] exp_drop;
    logic [7:0] exp_byte;

    // {valid, lane, last, data}
    wire [10:0] obs = {out_valid, out_lane, out_last, out_data};

    byte_lane_reader #(.CNT_W(8)) dut (
        .clk(clk), .areset(areset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_byteena(in_byteena),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .drop_cnt(drop_cnt), .byte_cnt(byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        areset = 1'b1;
        in_valid = 1'b1; in_data = 16'hFFFF; in_byteena = 2'b11;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (obs !== 11'h000) $display("FAIL reset_out: got %h expected %h", obs, 11'h000);
        else pass_cnt++;
        total_cnt++;
        if ({in_ready, drop_cnt, byte_cnt} !== {1'b1, 8'h00, 8'h00})
            $display("FAIL reset_cnt: got %b/%h/%h expected 1/00/00", in_ready, drop_cnt, byte_cnt);
        else pass_cnt++;
        in_valid = 1'b0; in_data = 16'h0000; in_byteena = 2'b00;
        areset = 1'b0;
        exp_drop = 8'h00; exp_byte = 8'h00;
    endtask

    task automatic test_dual();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'hAA55; in_byteena = 2'b11;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if ({obs, in_ready} !== {1'b1, 1'b0, 1'b0, 8'h55, 1'b0})
            $display("FAIL dual_lane0: got %h rdy %b expected %h rdy 0", obs, in_ready, {1'b1, 1'b0, 1'b0, 8'h55});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'hAA})
            $display("FAIL dual_lane1: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 8'hAA});
        else pass_cnt++;
        @(negedge clk);
        exp_byte = exp_byte + 8'd2;
        total_cnt++;
        if ({out_valid, in_ready, byte_cnt} !== {1'b0, 1'b1, exp_byte})
            $display("FAIL dual_done: got v%b r%b cnt %h expected v0 r1 cnt %h", out_valid, in_ready, byte_cnt, exp_byte);
        else pass_cnt++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 16'h1234; in_byteena = 2'b10;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'h12})
            $display("FAIL single_hi: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 8'h12});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL single_hi_idle: got v%b r%b expected v0 r1", out_valid, in_ready);
        else pass_cnt++;
        in_valid = 1'b1; in_byteena = 2'b01;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b1, 8'h34})
            $display("FAIL single_lo: got %h expected %h", obs, {1'b1, 1'b0, 1'b1, 8'h34});
        else pass_cnt++;
        @(negedge clk);
        exp_byte = exp_byte + 8'd2;
        total_cnt++;
        if ({out_valid, byte_cnt} !== {1'b0, exp_byte})
            $display("FAIL single_cnt: got v%b cnt %h expected v0 cnt %h", out_valid, byte_cnt, exp_byte);
        else pass_cnt++;
    endtask

    task automatic test_drop();
        in_valid = 1'b1; in_data = 16'hBEEF; in_byteena = 2'b00;
        @(negedge clk);
        in_valid = 1'b0;
        exp_drop = exp_drop + 8'd1;
        total_cnt++;
        if ({out_valid, in_ready, drop_cnt, byte_cnt} !== {1'b0, 1'b1, exp_drop, exp_byte})
            $display("FAIL drop: got v%b r%b drop %h byte %h expected v0 r1 drop %h byte %h",
                     out_valid, in_ready, drop_cnt, byte_cnt, exp_drop, exp_byte);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hCAFE; in_byteena = 2'b11;
        @(negedge clk);
        // A competing word offered during the stall must be ignored.
        in_data = 16'h1111; in_byteena = 2'b10;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({obs, in_ready} !== {1'b1, 1'b0, 1'b0, 8'hFE, 1'b0})
                $display("FAIL stall_hold%0d: got %h rdy %b expected %h rdy 0", i, obs, in_ready, {1'b1, 1'b0, 1'b0, 8'hFE});
            else pass_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'hFE})
            $display("FAIL stall_last_lo: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 8'hFE});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'hCA})
            $display("FAIL stall_hi: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 8'hCA});
        else pass_cnt++;
        @(negedge clk);
        exp_byte = exp_byte + 8'd2;
        total_cnt++;
        if ({out_valid, drop_cnt, byte_cnt} !== {1'b0, exp_drop, exp_byte})
            $display("FAIL stall_cnt: got v%b drop %h byte %h expected v0 drop %h byte %h",
                     out_valid, drop_cnt, byte_cnt, exp_drop, exp_byte);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h5A3C; in_byteena = 2'b11;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h3C})
            $display("FAIL areset_lo: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 8'h3C});
        else pass_cnt++;
        @(posedge clk);
        #2;
        total_cnt++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'h5A})
            $display("FAIL areset_hi: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 8'h5A});
        else pass_cnt++;
        areset = 1'b1;
        #1;
        total_cnt++;
        if ({obs, in_ready, drop_cnt, byte_cnt} !== {11'h000, 1'b1, 8'h00, 8'h00})
            $display("FAIL areset_async: got %h rdy %b drop %h byte %h expected 000 rdy 1 drop 00 byte 00",
                     obs, in_ready, drop_cnt, byte_cnt);
        else pass_cnt++;
        @(negedge clk);
        areset = 1'b0;
        exp_drop = 8'h00; exp_byte = 8'h00;
        @(negedge clk);
        total_cnt++;
        if ({obs, byte_cnt} !== {11'h000, 8'h00})
            $display("FAIL areset_abort: got %h byte %h expected 000 byte 00", obs, byte_cnt);
        else pass_cnt++;
    endtask

    task automatic test_drop_wrap();
        in_valid = 1'b1; in_data = 16'h0F0F; in_byteena = 2'b00;
        repeat (255) @(negedge clk);
        total_cnt++;
        if (drop_cnt !== 8'hFF) $display("FAIL wrap_pre: got %h expected ff", drop_cnt);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if ({drop_cnt, byte_cnt, out_valid} !== {8'h00, exp_byte, 1'b0})
            $display("FAIL wrap: got drop %h byte %h v%b expected drop 00 byte %h v0",
                     drop_cnt, byte_cnt, out_valid, exp_byte);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        exp_drop = 8'h00; exp_byte = 8'h00;
        areset = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_byteena = 2'b00; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_dual();
        test_single();
        test_drop();
        test_stall();
        test_async_reset();
        test_drop_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
